// File: rtl/code_checker_pkg.sv
// code_checker_pkg: state encodings and entry constants shared by the code checker.
package code_checker_pkg;
    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        FULL    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;
    localparam int NUM_DIGITS = 4;
endpackage

// File: rtl/code_checker_if.sv
// code_checker_if: keypad/controller signals of the code checker.
interface code_checker_if;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       clear;
    logic       Verificar;
    logic       Correct;
    logic       Blocked;
    logic [2:0] digit_count;
    logic [2:0] Fallos;
    modport master (output key_valid, key_digit, clear, Verificar,
                    input  Correct, Blocked, digit_count, Fallos);
    modport slave  (input  key_valid, key_digit, clear, Verificar,
                    output Correct, Blocked, digit_count, Fallos);
endinterface

// File: rtl/code_checker_lockout_timer.sv
// lockout_timer: loadable 16-bit down-counter; done flags the final count of a run.
module lockout_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done
);
    logic [15:0] count;
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            count <= value;
            busy  <= 1'b1;
        end else if (busy) begin
            if (count == 16'd0) busy <= 1'b0;
            else count <= count - 16'd1;
        end
    end
    assign done = busy && count == 16'd0;
endmodule

// File: rtl/code_checker.sv
// code_checker: four-digit code entry with consecutive-failure lockout.
module code_checker
    import code_checker_pkg::*;
#(
    parameter logic [15:0] CODE        = 16'h1234,
    parameter int          MAX_FAILS   = 3,
    parameter int          LOCK_CYCLES = 1000
) (
    input logic        clock,
    input logic        reset,
    code_checker_if.slave bus
);
    localparam logic [2:0] MF = 3'(MAX_FAILS);
    state_t      state;
    logic [15:0] buffer;
    logic [15:0] shifted;
    logic [2:0]  fail_next;
    logic        load, busy, done;
    assign shifted   = {buffer[11:0], bus.key_digit};
    assign fail_next = (bus.Fallos >= MF) ? MF : bus.Fallos + 3'd1;
    assign load      = state != LOCKOUT && bus.Verificar && !bus.Correct && fail_next == MF;
    lockout_timer u_timer (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .value (16'(LOCK_CYCLES - 1)),
        .busy  (busy),
        .done  (done)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ENTRY;
            buffer          <= '0;
            bus.digit_count <= '0;
            bus.Correct     <= 1'b0;
            bus.Blocked     <= 1'b0;
            bus.Fallos      <= '0;
        end else begin
            case (state)
                ENTRY, FULL: begin
                    if (bus.Verificar) begin
                        buffer          <= '0;
                        bus.digit_count <= '0;
                        bus.Correct     <= 1'b0;
                        bus.Fallos      <= bus.Correct ? 3'd0 : fail_next;
                        bus.Blocked     <= load;
                        state           <= load ? LOCKOUT : ENTRY;
                    end else if (bus.clear) begin
                        buffer          <= '0;
                        bus.digit_count <= '0;
                        bus.Correct     <= 1'b0;
                        state           <= ENTRY;
                    end else if (bus.key_valid && state == ENTRY) begin
                        buffer          <= shifted;
                        bus.digit_count <= bus.digit_count + 3'd1;
                        if (bus.digit_count == 3'(NUM_DIGITS - 1)) begin
                            state       <= FULL;
                            bus.Correct <= shifted == CODE;
                        end
                    end
                end
                LOCKOUT: begin
                    // Leaving also when the timer is idle keeps the FSM from sticking.
                    if (done || !busy) begin
                        state       <= ENTRY;
                        bus.Blocked <= 1'b0;
                        bus.Fallos  <= '0;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end
endmodule

// File: tb/tb_code_checker.sv
// tb_code_checker: directed scenarios plus random traffic against a queue-based model.
module tb_code_checker;
    localparam logic [15:0] CODE = 16'h1234;
    localparam int MAXF = 3;
    localparam int LOCK = 8;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    code_checker_if bus ();
    code_checker #(.CODE(CODE), .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int digits[$];
    int fails = 0;
    int lock_left = 0;

    function automatic bit code_ok();
        int v = 0;
        if (digits.size() != 4) return 1'b0;
        foreach (digits[i]) v = v * 16 + digits[i];
        return v == int'(CODE);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit kv, input int kd, input bit clr, input bit ver, input bit rst);
        bit ok;
        reset         = rst;
        bus.key_valid = kv;
        bus.key_digit = 4'(kd);
        bus.clear     = clr;
        bus.Verificar = ver;
        ok = code_ok();
        @(posedge clock);
        #1;
        if (rst) begin
            digits.delete();
            fails = 0;
            lock_left = 0;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (ver) begin
            if (ok) fails = 0;
            else begin
                fails = (fails + 1 > MAXF) ? MAXF : fails + 1;
                if (fails == MAXF) lock_left = LOCK;
            end
            digits.delete();
        end else if (clr) begin
            digits.delete();
        end else if (kv && digits.size() < 4) begin
            digits.push_back(kd);
        end
        check("correct", int'(bus.Correct), int'(code_ok()));
        check("blocked", int'(bus.Blocked), int'(lock_left > 0));
        check("digit_count", int'(bus.digit_count), digits.size());
        check("fallos", int'(bus.Fallos), fails);
        check("exclusive", int'(bus.Correct && bus.Blocked), 0);
    endtask

    task automatic key(input int d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic verify();
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic bad_try();
        key(1); key(2); key(3); key(5); verify();
    endtask

    initial begin
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle(1);
        key(1); key(2); key(3); key(4); idle(1); verify(); idle(1);
        bad_try(); bad_try(); bad_try(); idle(10);
        bad_try(); bad_try(); bad_try();
        key(1); key(2); key(3); key(4); verify(); idle(6);
        key(1); key(2); step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        key(1); key(2); key(3); key(4); idle(1); verify();
        key(1); key(2); key(3); step(1'b1, 4, 1'b0, 1'b1, 1'b0); idle(2);
        bad_try(); bad_try(); idle(2);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        key(1); key(2); key(3); key(4); idle(2); verify();
        for (int i = 0; i < 4000; i++) begin
            int r = int'($urandom_range(0, 99));
            int pos = digits.size();
            int d = (pos < 4 && $urandom_range(0, 3) != 0) ? int'((CODE >> (4 * (3 - pos))) & 16'hF)
                                                           : int'($urandom_range(0, 15));
            step(r < 55, d, r >= 88 && r < 93, r >= 93 || r == 50, r == 99 && $urandom_range(0, 3) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
